// File: rtl/csr_nfa_traversal.sv
// Dual-stream NFA walker over a CSR graph held in a read-only 512-bit BRAM.
// Each step consumes one char per stream, walks every state row, and commits the next active sets.
module csr_nfa_traversal #(
    parameter int size_range = 7,
    parameter int RD_LAT     = 2
) (
    input  logic         tb_clk,
    input  logic         reset,
    input  logic [23:0]  size,
    output logic [16:0]  rd_address,
    input  logic [511:0] rd_bus,
    output logic         input_char_flag,
    input  logic [7:0]   input_char,
    input  logic [7:0]   input_char_2,
    output logic [19:0]  i,
    output logic         accepting_match_flag,
    output logic         accepting_match_flag_2
);

    localparam int SW = $clog2(size_range + 1);
    localparam int WW = $clog2(RD_LAT + 1);
    localparam logic [size_range-1:0] STATE0 = size_range'(1);

    typedef enum logic [2:0] {REQ, LOAD, ROW, ROW_WAIT, EDGE, EDGE_WAIT, COMMIT} state_t;

    state_t                 state_reg, state_next;
    logic [SW-1:0]          s_reg;
    logic [7:0]             c1_reg, c2_reg;
    logic [size_range-1:0]  cur1_reg, cur2_reg, next1_reg, next2_reg;
    logic [WW-1:0]          wait_cnt_reg;
    logic [16:0]            edge_base_reg, rem_reg, k_reg;
    logic [16:0]            rd_address_reg;
    logic [19:0]            i_reg;
    logic                   flag1_reg, flag2_reg;

    logic [23:0]            eff_size;
    logic                   wait_done, last_state, s_act1, s_act2, row_fetch, last_word;
    logic                   row_flag1, row_flag2;
    logic [size_range-1:0]  hit1 [16];
    logic [size_range-1:0]  hit2 [16];
    logic [size_range-1:0]  edge_hits1, edge_hits2;
    logic [15:0]            unused_edge_bytes;

    assign eff_size   = (size > 24'(size_range)) ? 24'(size_range) : size;
    assign wait_done  = (wait_cnt_reg == WW'(RD_LAT));
    assign last_state = (s_reg == eff_size[SW-1:0] - SW'(1));
    assign s_act1     = cur1_reg[s_reg];
    assign s_act2     = cur2_reg[s_reg];
    assign row_fetch  = (s_act1 | s_act2) && (rd_bus[33:17] != 17'd0);
    assign last_word  = (rem_reg <= 17'd16);
    assign row_flag1  = rd_bus[34] & s_act1;
    assign row_flag2  = rd_bus[34] & s_act2;

    // Per-edge contribution masks; an edge only counts if it lies within edge_cnt and targets a live state.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_edge
            logic [7:0] lo, hi, tgt;
            logic       live;
            assign lo   = rd_bus[32*gi +: 8];
            assign hi   = rd_bus[32*gi+8 +: 8];
            assign tgt  = rd_bus[32*gi+16 +: 8];
            assign live = (17'(gi) < rem_reg) && ({16'd0, tgt} < eff_size);
            assign hit1[gi] = (live && s_act1 && lo <= c1_reg && c1_reg <= hi) ? (STATE0 << tgt) : '0;
            assign hit2[gi] = (live && s_act2 && lo <= c2_reg && c2_reg <= hi) ? (STATE0 << tgt) : '0;
            assign unused_edge_bytes[gi] = ^rd_bus[32*gi+24 +: 8];
        end
    endgenerate

    always_comb begin
        edge_hits1 = '0;
        edge_hits2 = '0;
        for (int j = 0; j < 16; j++) begin
            edge_hits1 = edge_hits1 | hit1[j];
            edge_hits2 = edge_hits2 | hit2[j];
        end
    end

    always_ff @(posedge tb_clk) begin
        if (!reset) state_reg <= REQ;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            REQ:       state_next = LOAD;
            LOAD:      state_next = (eff_size == 24'd0) ? REQ : ROW;
            ROW:       state_next = ROW_WAIT;
            ROW_WAIT:  if (wait_done) state_next = row_fetch ? EDGE : (last_state ? COMMIT : ROW);
            EDGE:      state_next = EDGE_WAIT;
            EDGE_WAIT: if (wait_done) state_next = !last_word ? EDGE : (last_state ? COMMIT : ROW);
            COMMIT:    state_next = REQ;
            default:   state_next = REQ;
        endcase
    end

    always_ff @(posedge tb_clk) begin
        if (!reset) begin
            s_reg          <= '0;
            c1_reg         <= '0;
            c2_reg         <= '0;
            cur1_reg       <= STATE0;
            cur2_reg       <= STATE0;
            next1_reg      <= '0;
            next2_reg      <= '0;
            wait_cnt_reg   <= '0;
            edge_base_reg  <= '0;
            rem_reg        <= '0;
            k_reg          <= '0;
            rd_address_reg <= '0;
            i_reg          <= '0;
            flag1_reg      <= 1'b0;
            flag2_reg      <= 1'b0;
        end else begin
            flag1_reg <= 1'b0;
            flag2_reg <= 1'b0;
            i_reg     <= '0;
            case (state_reg)
                LOAD: begin
                    c1_reg <= input_char;
                    c2_reg <= input_char_2;
                    s_reg  <= '0;
                end
                ROW: begin
                    rd_address_reg <= 17'(s_reg);
                    wait_cnt_reg   <= '0;
                end
                ROW_WAIT: begin
                    if (!wait_done) begin
                        wait_cnt_reg <= wait_cnt_reg + WW'(1);
                    end else begin
                        flag1_reg     <= row_flag1;
                        flag2_reg     <= row_flag2;
                        i_reg         <= (row_flag1 | row_flag2) ? 20'(s_reg) : '0;
                        edge_base_reg <= rd_bus[16:0];
                        rem_reg       <= rd_bus[33:17];
                        k_reg         <= '0;
                        if (!row_fetch && !last_state) s_reg <= s_reg + SW'(1);
                    end
                end
                EDGE: begin
                    rd_address_reg <= edge_base_reg + k_reg;
                    wait_cnt_reg   <= '0;
                end
                EDGE_WAIT: begin
                    if (!wait_done) begin
                        wait_cnt_reg <= wait_cnt_reg + WW'(1);
                    end else begin
                        next1_reg <= next1_reg | edge_hits1;
                        next2_reg <= next2_reg | edge_hits2;
                        if (!last_word) begin
                            rem_reg <= rem_reg - 17'd16;
                            k_reg   <= k_reg + 17'd1;
                        end else if (!last_state) begin
                            s_reg <= s_reg + SW'(1);
                        end
                    end
                end
                COMMIT: begin
                    // State 0 stays live so a match may start at any character.
                    cur1_reg  <= next1_reg | STATE0;
                    cur2_reg  <= next2_reg | STATE0;
                    next1_reg <= '0;
                    next2_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign rd_address             = rd_address_reg;
    assign input_char_flag        = (state_reg == REQ) && reset;
    assign i                      = i_reg;
    assign accepting_match_flag   = flag1_reg;
    assign accepting_match_flag_2 = flag2_reg;

endmodule

// File: tb/tb_csr_nfa_traversal.sv
// Directed bench for csr_nfa_traversal: BRAM model with 2-cycle latency, char feeder and match monitor.
module tb_csr_nfa_traversal;

    logic         tb_clk = 1'b0;
    logic         reset;
    logic [23:0]  size;
    logic [16:0]  rd_address;
    logic [511:0] rd_bus;
    logic         input_char_flag;
    logic [7:0]   input_char, input_char_2;
    logic [19:0]  i;
    logic         accepting_match_flag, accepting_match_flag_2;

    always #5 tb_clk = ~tb_clk;

    csr_nfa_traversal #(.size_range(7), .RD_LAT(2)) dut (
        .tb_clk                 (tb_clk),
        .reset                  (reset),
        .size                   (size),
        .rd_address             (rd_address),
        .rd_bus                 (rd_bus),
        .input_char_flag        (input_char_flag),
        .input_char             (input_char),
        .input_char_2           (input_char_2),
        .i                      (i),
        .accepting_match_flag   (accepting_match_flag),
        .accepting_match_flag_2 (accepting_match_flag_2)
    );

    logic [511:0] mem [0:63];
    logic [511:0] pipe1;
    always_ff @(posedge tb_clk) begin
        pipe1  <= mem[rd_address[5:0]];
        rd_bus <= pipe1;
    end

    int check_count = 0;
    int error_count = 0;
    int feed_count  = 0;

    int m1_count = 0, m2_count = 0, m1_feed = 0, m2_feed = 0;
    int dbl_count = 0, idle_i_bad = 0, addr_nz_count = 0;
    logic [19:0] m1_i = '0, m2_i = '0;
    logic prev1 = 1'b0, prev2 = 1'b0;

    always @(negedge tb_clk) begin
        if (reset === 1'b1) begin
            if (accepting_match_flag) begin
                m1_count++; m1_i = i; m1_feed = feed_count;
                if (prev1) dbl_count++;
            end
            if (accepting_match_flag_2) begin
                m2_count++; m2_i = i; m2_feed = feed_count;
                if (prev2) dbl_count++;
            end
            if (!accepting_match_flag && !accepting_match_flag_2 && i != 20'd0) idle_i_bad++;
            if (rd_address != 17'd0) addr_nz_count++;
        end
        prev1 = accepting_match_flag;
        prev2 = accepting_match_flag_2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_row(input logic [16:0] base, input logic [16:0] cnt, input logic acc);
        logic [511:0] r;
        r = '0;
        r[16:0]  = base;
        r[33:17] = cnt;
        r[34]    = acc;
        return r;
    endfunction

    task automatic set_edge(input int w, input int j, input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] tgt);
        mem[w][32*j +: 32] = {8'h00, tgt, hi, lo};
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 64; a++) mem[a] = '0;
    endtask

    task automatic load_chain();
        clear_mem();
        mem[0] = mk_row(17'd16, 17'd1, 1'b0);
        mem[1] = mk_row(17'd17, 17'd1, 1'b0);
        mem[2] = mk_row(17'd0, 17'd0, 1'b1);
        set_edge(16, 0, "a", "a", 8'd1);
        set_edge(17, 0, "b", "b", 8'd2);
    endtask

    // 20 edges from state 0; fillers are inverted ranges pointing at the accepting state.
    task automatic load_wide();
        clear_mem();
        mem[0] = mk_row(17'd32, 17'd20, 1'b0);
        for (int r = 1; r < 7; r++) mem[r] = mk_row(17'd0, 17'd0, r == 4);
        for (int j = 0; j < 16; j++) begin
            set_edge(32, j, 8'h39, 8'h30, 8'd4);
            set_edge(33, j, 8'h39, 8'h30, 8'd4);
        end
        set_edge(33, 1, 8'h30, 8'h39, 8'd4);
        set_edge(33, 2, "z", "z", 8'd5);
        set_edge(33, 3, 8'h00, 8'hFF, 8'd12);
        set_edge(33, 4, 8'h00, 8'hFF, 8'd4);
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        input_char = 8'h00;
        input_char_2 = 8'h00;
        repeat (2) @(posedge tb_clk);
    endtask

    task automatic release_reset();
        @(posedge tb_clk);
        #1 reset = 1'b1;
    endtask

    task automatic feed(input logic [7:0] a, input logic [7:0] b, output int waited);
        waited = 0;
        do begin
            @(negedge tb_clk);
            waited++;
        end while (input_char_flag !== 1'b1 && waited < 60);
        if (input_char_flag !== 1'b1) check_eq("req_timeout", 32'd0, 32'd1);
        input_char   = a;
        input_char_2 = b;
        feed_count++;
        $display("feed %0d: c1=%02h c2=%02h after %0d cycles", feed_count, a, b, waited);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, b1, b2, bz, n;

        // Reset behaviour and first request latency
        size = 24'd7;
        clear_mem();
        reset = 1'b0;
        input_char = 8'h00;
        input_char_2 = 8'h00;
        for (int c = 0; c < 2; c++) begin
            @(negedge tb_clk);
            check_eq("rst_flag1", 32'(accepting_match_flag), 32'd0);
            check_eq("rst_flag2", 32'(accepting_match_flag_2), 32'd0);
            check_eq("rst_i", 32'(i), 32'd0);
            check_eq("rst_addr", 32'(rd_address), 32'd0);
        end
        release_reset();
        feed(8'h00, 8'h00, w);
        check_eq("first_req_latency", 32'(w <= 2), 32'd1);

        // Chain graph, stream1 "abX", stream2 "zzz"
        hold_reset();
        load_chain();
        size = 24'd3;
        release_reset();
        b1 = m1_count; b2 = m2_count; feed_count = 0;
        feed("a", "z", w); feed("b", "z", w); feed("X", "z", w); feed(8'h00, 8'h00, w);
        check_eq("abX_count1", 32'(m1_count - b1), 32'd1);
        check_eq("abX_count2", 32'(m2_count - b2), 32'd0);
        check_eq("abX_i", 32'(m1_i), 32'd2);
        check_eq("abX_feed", 32'(m1_feed), 32'd3);

        // Chain graph, stream1 "ab", stream2 "aa"
        hold_reset();
        release_reset();
        b1 = m1_count; b2 = m2_count; feed_count = 0;
        feed("a", "a", w); feed("b", "a", w); feed(8'h00, 8'h00, w); feed(8'h00, 8'h00, w);
        check_eq("ab_aa_count1", 32'(m1_count - b1), 32'd1);
        check_eq("ab_aa_count2", 32'(m2_count - b2), 32'd0);
        check_eq("ab_aa_i", 32'(m1_i), 32'd2);
        check_eq("ab_aa_feed", 32'(m1_feed), 32'd3);

        // Wide state 0: '5' hits edge 17, 'z' only reaches non-accepting state 5
        hold_reset();
        load_wide();
        size = 24'd7;
        release_reset();
        b1 = m1_count; b2 = m2_count; feed_count = 0;
        feed("5", "z", w); feed(8'h00, "z", w); feed(8'h00, 8'h00, w);
        check_eq("wide5_count1", 32'(m1_count - b1), 32'd1);
        check_eq("wide5_i", 32'(m1_i), 32'd4);
        check_eq("wide5_feed", 32'(m1_feed), 32'd2);
        check_eq("widez_count2", 32'(m2_count - b2), 32'd0);

        // Range edges: '9' and '0' inside, ':' and '/' outside
        hold_reset();
        release_reset();
        b1 = m1_count; b2 = m2_count; feed_count = 0;
        feed("9", "/", w); feed(":", "0", w); feed(8'h00, 8'h00, w); feed(8'h00, 8'h00, w);
        check_eq("range_count1", 32'(m1_count - b1), 32'd1);
        check_eq("range_feed1", 32'(m1_feed), 32'd2);
        check_eq("range_count2", 32'(m2_count - b2), 32'd1);
        check_eq("range_i2", 32'(m2_i), 32'd4);
        check_eq("range_feed2", 32'(m2_feed), 32'd3);

        // Empty graph: back-to-back requests, no reads, no flags
        hold_reset();
        size = 24'd0;
        release_reset();
        b1 = m1_count; b2 = m2_count; bz = addr_nz_count;
        feed("5", "5", w);
        for (int k = 0; k < 5; k++) begin
            feed("5", "5", w);
            check_eq("size0_gap", 32'(w <= 2), 32'd1);
        end
        check_eq("size0_addr", 32'(addr_nz_count - bz), 32'd0);
        check_eq("size0_flags", 32'((m1_count - b1) + (m2_count - b2)), 32'd0);

        // Reset during the second edge-word fetch
        hold_reset();
        size = 24'd7;
        release_reset();
        b1 = m1_count; b2 = m2_count;
        feed("5", "5", w);
        n = 0;
        do begin
            @(negedge tb_clk);
            n++;
        end while (rd_address != 17'd33 && n < 100);
        check_eq("midrst_reach_edge", 32'(rd_address), 32'd33);
        reset = 1'b0;
        input_char = 8'h00;
        input_char_2 = 8'h00;
        @(posedge tb_clk);
        #1;
        check_eq("midrst_flag1", 32'(accepting_match_flag), 32'd0);
        check_eq("midrst_flag2", 32'(accepting_match_flag_2), 32'd0);
        check_eq("midrst_i", 32'(i), 32'd0);
        check_eq("midrst_addr", 32'(rd_address), 32'd0);
        check_eq("midrst_cur1", 32'(dut.cur1_reg), 32'd1);
        check_eq("midrst_cur2", 32'(dut.cur2_reg), 32'd1);
        reset = 1'b1;
        @(negedge tb_clk);
        check_eq("midrst_restart_req", 32'(input_char_flag), 32'd1);
        feed(8'h00, 8'h00, w); feed(8'h00, 8'h00, w);
        check_eq("midrst_no_match", 32'((m1_count - b1) + (m2_count - b2)), 32'd0);

        check_eq("single_cycle_pulses", 32'(dbl_count), 32'd0);
        check_eq("idle_i_zero", 32'(idle_i_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
